// File: rtl/commit_perf_counters.sv
// Commit statistics unit sitting beside the ROB on the commit interface.
// Counts commits, enabled cycles, idle cycles and a commits-per-cycle
// histogram, with an atomic snapshot handshake and a fixed-length IPC window.
//
// Snapshot FSM
//   state  | meaning
//   S_IDLE | no snapshot outstanding; snap_req captures total/cycles
//   S_HELD | snap_* hold a captured snapshot until snap_ack
module commit_perf_counters #(
    parameter int COMMIT_WIDTH  = 4,
    parameter int CNT_WIDTH     = 32,
    parameter bit SATURATE      = 1'b1,
    parameter int WINDOW_CYCLES = 1024,
    parameter int NC_W          = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [COMMIT_WIDTH-1:0]              commit_valid,
    input  logic                                 enable,
    input  logic                                 clear,
    output logic [CNT_WIDTH-1:0]                 total_commits,
    output logic [CNT_WIDTH-1:0]                 total_cycles,
    output logic [CNT_WIDTH-1:0]                 idle_cycles,
    output logic [(COMMIT_WIDTH+1)*CNT_WIDTH-1:0] hist_flat,
    output logic [COMMIT_WIDTH+3:0]              ovf_flags,
    input  logic                                 snap_req,
    output logic                                 snap_valid,
    input  logic                                 snap_ack,
    output logic [CNT_WIDTH-1:0]                 snap_total,
    output logic [CNT_WIDTH-1:0]                 snap_cycles,
    output logic [CNT_WIDTH-1:0]                 win_commits,
    output logic                                 win_done
);

    typedef enum logic {S_IDLE, S_HELD} snap_state_t;

    // Returns {carry, next value}; next value is already saturated or wrapped.
    function automatic logic [CNT_WIDTH:0] add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_WIDTH] && SATURATE) s[CNT_WIDTH-1:0] = '1;
        return s;
    endfunction

    logic [NC_W-1:0]      nc;
    logic [CNT_WIDTH-1:0] hist [COMMIT_WIDTH+1];
    logic [CNT_WIDTH:0]   tot_sum;
    logic [CNT_WIDTH:0]   cyc_sum;
    logic [CNT_WIDTH:0]   idle_sum;
    logic [CNT_WIDTH:0]   hist_sum [COMMIT_WIDTH+1];
    snap_state_t          snap_state;
    snap_state_t          snap_state_n;
    logic                 capture;

    // Popcount of the commit vector: number of instructions retired this cycle.
    always_comb begin
        nc = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) nc = nc + NC_W'(commit_valid[i]);
    end

    // Candidate next values of every live counter, assuming an enabled cycle.
    always_comb begin
        tot_sum  = add_cnt(total_commits, CNT_WIDTH'(nc));
        cyc_sum  = add_cnt(total_cycles, CNT_WIDTH'(1));
        idle_sum = add_cnt(idle_cycles, CNT_WIDTH'(nc == '0));
        for (int k = 0; k <= COMMIT_WIDTH; k++)
            hist_sum[k] = add_cnt(hist[k], CNT_WIDTH'(nc == NC_W'(k)));
    end

    // Live counters and sticky overflow flags; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            total_commits <= '0;
            total_cycles  <= '0;
            idle_cycles   <= '0;
            ovf_flags     <= '0;
            for (int k = 0; k <= COMMIT_WIDTH; k++) hist[k] <= '0;
        end else if (enable) begin
            total_commits <= tot_sum[CNT_WIDTH-1:0];
            total_cycles  <= cyc_sum[CNT_WIDTH-1:0];
            idle_cycles   <= idle_sum[CNT_WIDTH-1:0];
            ovf_flags[0]  <= ovf_flags[0] | tot_sum[CNT_WIDTH];
            ovf_flags[1]  <= ovf_flags[1] | cyc_sum[CNT_WIDTH];
            ovf_flags[2]  <= ovf_flags[2] | idle_sum[CNT_WIDTH];
            for (int k = 0; k <= COMMIT_WIDTH; k++) begin
                hist[k]          <= hist_sum[k][CNT_WIDTH-1:0];
                ovf_flags[3 + k] <= ovf_flags[3 + k] | hist_sum[k][CNT_WIDTH];
            end
        end
    end

    for (genvar k = 0; k <= COMMIT_WIDTH; k++) begin : g_hist
        assign hist_flat[k*CNT_WIDTH +: CNT_WIDTH] = hist[k];
    end

    // Snapshot state register.
    always_ff @(posedge clk) begin
        if (reset) snap_state <= S_IDLE;
        else       snap_state <= snap_state_n;
    end

    // Snapshot next state; requests while a snapshot is held are dropped.
    always_comb begin
        snap_state_n = snap_state;
        capture      = 1'b0;
        case (snap_state)
            S_IDLE: if (snap_req) begin
                capture      = 1'b1;
                snap_state_n = S_HELD;
            end
            S_HELD: if (snap_ack) snap_state_n = S_IDLE;
            default: snap_state_n = S_IDLE;
        endcase
    end

    assign snap_valid = (snap_state == S_HELD);

    // Capture the post-increment totals; a same-cycle clear does not zero the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_total  <= '0;
            snap_cycles <= '0;
        end else if (capture) begin
            snap_total  <= enable ? tot_sum[CNT_WIDTH-1:0] : total_commits;
            snap_cycles <= enable ? cyc_sum[CNT_WIDTH-1:0] : total_cycles;
        end
    end

    if (WINDOW_CYCLES > 0) begin : g_win
        localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

        logic [WC_W-1:0]      win_cnt;
        logic [CNT_WIDTH-1:0] win_acc;
        logic [CNT_WIDTH:0]   acc_sum;
        logic [CNT_WIDTH-1:0] acc_next;
        logic                 win_last;

        // Window accumulator always saturates, independent of the live-counter mode.
        always_comb begin
            acc_sum  = {1'b0, win_acc} + (CNT_WIDTH + 1)'(nc);
            acc_next = acc_sum[CNT_WIDTH] ? '1 : acc_sum[CNT_WIDTH-1:0];
            win_last = (win_cnt == WC_W'(WINDOW_CYCLES - 1));
        end

        // Window position/accumulator; publishes the total on the last enabled cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                win_cnt     <= '0;
                win_acc     <= '0;
                win_commits <= '0;
                win_done    <= 1'b0;
            end else begin
                win_done <= 1'b0;
                if (clear) begin
                    win_cnt <= '0;
                    win_acc <= '0;
                end else if (enable) begin
                    if (win_last) begin
                        win_commits <= acc_next;
                        win_done    <= 1'b1;
                        win_cnt     <= '0;
                        win_acc     <= '0;
                    end else begin
                        win_cnt <= win_cnt + WC_W'(1);
                        win_acc <= acc_next;
                    end
                end
            end
        end
    end else begin : g_no_win
        assign win_commits = '0;
        assign win_done    = 1'b0;
    end

endmodule

// File: doc/commit_perf_counters.md
Name: commit_perf_counters

Overview:
Parametrised commit-statistics unit; next generation of the commit-total counter that sits beside the ROB on the commit interface. Consumes the per-slot commit_valid vector every cycle. Maintains total commits, enabled cycles, zero-commit (idle) cycles and a commits-per-cycle histogram, with selectable saturate/wrap overflow handling. Adds an atomic snapshot handshake and a fixed-length IPC window measurement for debug/performance readout.

Parameters:
COMMIT_WIDTH, 4, number of commit slots per cycle (width of commit_valid); ≥1
CNT_WIDTH, 32, width of every counter and snapshot register; ≥4
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap modulo 2^CNT_WIDTH
WINDOW_CYCLES, 1024, enabled cycles per IPC window; 0 disables window logic (win_done never pulses, win_commits stays 0)
NC_W, $clog2(COMMIT_WIDTH+1), derived; width of per-cycle commit count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
commit_valid  in  COMMIT_WIDTH  per-slot commit valid from commit interface, any bit pattern legal
enable  in  1  count enable; 0 freezes all live counters and the window counter
clear  in  1  synchronous clear of live counters, overflow flags and window
total_commits  out  CNT_WIDTH  live sum of committed instructions
total_cycles  out  CNT_WIDTH  live count of enabled cycles
idle_cycles  out  CNT_WIDTH  live count of enabled cycles with zero commits
hist_flat  out  (COMMIT_WIDTH+1)*CNT_WIDTH  bin k (bits k*CNT_WIDTH +: CNT_WIDTH) = enabled cycles with exactly k commits
ovf_flags  out  COMMIT_WIDTH+4  sticky overflow: [0] total, [1] cycles, [2] idle, [3+k] hist bin k
snap_req  in  1  snapshot request
snap_valid  out  1  snapshot registers hold a captured, unacknowledged snapshot
snap_ack  in  1  consumer acknowledges snapshot
snap_total  out  CNT_WIDTH  captured total_commits
snap_cycles  out  CNT_WIDTH  captured total_cycles
win_commits  out  CNT_WIDTH  commits in last completed window
win_done  out  1  one-cycle pulse when win_commits updates

Behaviour:
- Reset: every output, counter, flag, snapshot register, window counter = 0; snap_valid = 0. Reset overrides all inputs.
- nc = popcount(commit_valid), NC_W bits, combinational; independent of bit positions.
- Enabled cycle (enable=1, clear=0, reset=0): at the clock edge total += nc, cycles += 1, idle += (nc==0), hist[nc] += 1. Outputs are registers; update visible the cycle after sampling (latency 1). enable=0: all live counters and window hold.
- total add is wide: compute in CNT_WIDTH+1 bits; carry-out = overflow.
- Overflow: on carry-out set corresponding ovf_flags bit (sticky until reset/clear). SATURATE=1: counter loads all-ones and stays there. SATURATE=0: counter takes low CNT_WIDTH bits.
- clear: priority over increment; live counters, ovf_flags, window counter and window accumulator -> 0 at the edge; win_commits, snapshot registers and snap_valid are unaffected.
- Snapshot FSM, states IDLE / HELD:
  IDLE: snap_req=1 -> capture next-state values of total and cycles (including this cycle's increment, ignoring a simultaneous clear) into snap_*; go HELD; snap_valid=1 next cycle.
  HELD: snap_ack=1 -> IDLE, snap_valid=0 next cycle; snap_* retain values. snap_req while HELD is ignored (no recapture), including in the ack cycle.
  Snapshot capture is independent of enable (captures held values when enable=0).
- IPC window (WINDOW_CYCLES>0): window counter counts enabled cycles 0..WINDOW_CYCLES-1; accumulator adds nc each enabled cycle, saturating at all-ones. On the enabled cycle where the counter equals WINDOW_CYCLES-1: win_commits <= accumulator+nc, win_done=1 next cycle (one cycle), counter and accumulator restart at 0. win_done never asserted for two consecutive cycles unless WINDOW_CYCLES=1.
- Window and live counters are independent: live-counter saturation does not stop windows.

Test Plan:
- Reset then 10 enabled cycles with commit_valid=4'b1011 -> total_commits=30, total_cycles=10, idle_cycles=0, hist bin3=10, others 0, ovf_flags=0.
- Alternate commit_valid 4'b0000 / 4'b1111 for 8 cycles, enable low on cycles 3-4 -> total=12, cycles=6, idle=3, bin0=3, bin4=3; counters frozen while enable=0.
- CNT_WIDTH=8, SATURATE=1, commit_valid=4'b1111 for 70 cycles -> total=255 from cycle 64 onward, ovf_flags[0]=1, cycles=70; repeat with SATURATE=0 -> total=24 (280 mod 256), ovf_flags[0]=1.
- total=50, assert snap_req and clear in same cycle with nc=2 -> snap_total=52, snap_valid=1 next cycle, live total=0; second snap_req before ack ignored; snap_ack -> snap_valid=0, snap_total stays 52.
- WINDOW_CYCLES=4, nc sequence 1,2,0,3,4,4,4,4 -> win_done pulses after cycle 4 with win_commits=6 and after cycle 8 with win_commits=16; clear mid-window restarts count.
- Assert reset mid-run with snap_valid=1 and window half-full -> all outputs 0 next cycle, snap_valid=0, next window completes only after a full WINDOW_CYCLES enabled cycles.
